// File: rtl/inst_mem_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : inst_mem_loader_pkg                                        |
// | Description : Shared definitions for the run-time loadable instruction   |
// |               memory: bus widths, reset level, memory geometry and the   |
// |               loader state encoding.                                     |
// |               The CHECK state exists only when INST_LOAD_CHECKSUM_EN is  |
// |               defined.                                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package inst_mem_loader_pkg;

  localparam int          c_inst_addr_bus_w   = 32;
  localparam int          c_inst_bus_w        = 32;
  localparam logic [31:0] c_zero_word         = 32'h0000_0000;
  localparam logic        c_rst_enable        = 1'b1;
  localparam int          c_inst_mem_num      = 1024;
  localparam int          c_inst_mem_num_log2 = 10;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_LOAD  = 3'd1,
    LD_WRITE = 3'd2,
`ifdef INST_LOAD_CHECKSUM_EN
    LD_CHECK = 3'd3,
`endif
    LD_DONE  = 3'd4
  } ld_state_e;

endpackage : inst_mem_loader_pkg
`default_nettype wire

// File: rtl/inst_mem_loader_byte_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : inst_byte_packer                                           |
// | Description : Big-endian byte-to-word shifter. Each accepted byte enters |
// |               at the LSB end and moves up, so the first of four bytes    |
// |               ends in [31:24]. A 2-bit byte counter raises word_valid_o  |
// |               together with the fourth byte.                             |
// | Ports       : clk, rst        - clock, synchronous active-high reset     |
// |               clear_i         - restart byte counting                    |
// |               byte_valid_i    - byte_i is accepted this cycle            |
// |               byte_i          - incoming byte                            |
// |               word_o          - assembled word (registered)              |
// |               word_next_o     - word as it will be after this byte       |
// |               word_valid_o    - this byte completes a word               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module inst_byte_packer
  import inst_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [31:0] word_next_o,
  output logic        word_valid_o
);

  logic [31:0] word_q;
  logic [1:0]  byte_cnt_q;

  assign word_next_o  = {word_q[23:0], byte_i};
  assign word_valid_o = byte_valid_i && (byte_cnt_q == 2'd3);
  assign word_o       = word_q;

  always_ff @(posedge clk) begin
    if (rst == c_rst_enable) begin
      word_q     <= c_zero_word;
      byte_cnt_q <= 2'd0;
    end else if (clear_i) begin
      byte_cnt_q <= 2'd0;
    end else if (byte_valid_i) begin
      word_q     <= word_next_o;
      // Two-bit counter wraps to 0 on the fourth byte by itself.
      byte_cnt_q <= byte_cnt_q + 2'd1;
    end
  end

endmodule : inst_byte_packer
`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : inst_mem_loader                                            |
// | Description : Instruction RAM for the openmips fetch port, filled at run |
// |               time by a byte-serial loader. Fetch is combinational; the  |
// |               core sees ZeroWord (NOP) and a stall while loading.        |
// |               Optional macro INST_LOAD_CHECKSUM_EN adds a trailing       |
// |               32-bit XOR checksum phase and drives load_err.             |
// | Ports       : clk, rst       - clock, synchronous active-high reset      |
// |               ce, addr, inst - fetch enable, byte address, instruction   |
// |               load_start/len - begin a load of len words                 |
// |               load_valid/byte/ready - byte stream handshake              |
// |               load_done/err  - completion pulse, checksum mismatch       |
// |               stall_req      - hold the core pipeline                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int MEM_WORDS = c_inst_mem_num,
  parameter int ADDR_W    = c_inst_mem_num_log2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [31:0]       addr,
  output logic [31:0]       inst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_err,
  output logic              stall_req
);

  ld_state_e         state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   len_q;
  logic              load_ready_q;
  logic              load_done_q;
  logic              stall_q;
  logic [31:0]       mem_q [MEM_WORDS];

  logic [ADDR_W:0]   w_len_clamped;
  logic              w_last_word;
  logic              w_byte_acc;
  logic              w_clear;
  logic [31:0]       w_word;
  logic [31:0]       w_word_next;
  logic              w_word_valid;
  logic              w_unused;

  assign w_len_clamped = (load_len > (ADDR_W+1)'(MEM_WORDS)) ? (ADDR_W+1)'(MEM_WORDS)
                                                              : load_len;
  assign w_last_word   = (({1'b0, wr_ptr_q} + (ADDR_W+1)'(1)) == len_q);
  // load_ready is only ever high in LOAD/CHECK, so bytes offered at any other
  // time fall through without touching the packer.
  assign w_byte_acc    = load_valid && load_ready_q;
  assign w_clear       = (state_q == LD_IDLE) && load_start;

  inst_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (w_clear),
    .byte_valid_i (w_byte_acc),
    .byte_i       (load_byte),
    .word_o       (w_word),
    .word_next_o  (w_word_next),
    .word_valid_o (w_word_valid)
  );

  // Fetch path: zero latency, word index wraps modulo MEM_WORDS.
  assign inst = (ce && (state_q == LD_IDLE)) ? mem_q[addr[ADDR_W+1:2]] : c_zero_word;

  assign load_ready = load_ready_q;
  assign load_done  = load_done_q;
  assign stall_req  = stall_q;

`ifdef INST_LOAD_CHECKSUM_EN
  logic [31:0] csum_q;
  logic        err_q;
  assign load_err = err_q;
  assign w_unused = ^{addr[31:ADDR_W+2], addr[1:0]};
`else
  assign load_err = 1'b0;
  assign w_unused = ^{addr[31:ADDR_W+2], addr[1:0], w_word_next};
`endif

  // RAM write port; never reset so a reset mid-load keeps earlier words.
  always_ff @(posedge clk) begin
    if ((rst != c_rst_enable) && (state_q == LD_WRITE)) begin
      mem_q[wr_ptr_q] <= w_word;
    end
  end

  // Loader FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst == c_rst_enable) begin
      state_q      <= LD_IDLE;
      wr_ptr_q     <= '0;
      len_q        <= '0;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      stall_q      <= 1'b0;
`ifdef INST_LOAD_CHECKSUM_EN
      csum_q       <= c_zero_word;
      err_q        <= 1'b0;
`endif
    end else begin
      load_done_q <= 1'b0;
`ifdef INST_LOAD_CHECKSUM_EN
      err_q       <= 1'b0;
`endif
      case (state_q)
        LD_IDLE: begin
          if (load_start) begin
            len_q    <= w_len_clamped;
            wr_ptr_q <= '0;
            stall_q  <= 1'b1;
`ifdef INST_LOAD_CHECKSUM_EN
            csum_q   <= c_zero_word;
`endif
            if (w_len_clamped == '0) begin
              state_q     <= LD_DONE;
              load_done_q <= 1'b1;
            end else begin
              state_q      <= LD_LOAD;
              load_ready_q <= 1'b1;
            end
          end
        end

        LD_LOAD: begin
          if (w_word_valid) begin
            state_q      <= LD_WRITE;
            load_ready_q <= 1'b0;
          end
        end

        LD_WRITE: begin
          wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
`ifdef INST_LOAD_CHECKSUM_EN
          csum_q   <= csum_q ^ w_word;
`endif
          if (w_last_word) begin
`ifdef INST_LOAD_CHECKSUM_EN
            state_q      <= LD_CHECK;
            load_ready_q <= 1'b1;
`else
            state_q      <= LD_DONE;
            load_done_q  <= 1'b1;
`endif
          end else begin
            state_q      <= LD_LOAD;
            load_ready_q <= 1'b1;
          end
        end

`ifdef INST_LOAD_CHECKSUM_EN
        LD_CHECK: begin
          // Compare against the word including the byte arriving now, since
          // load_err must already be valid in the DONE cycle.
          if (w_word_valid) begin
            state_q      <= LD_DONE;
            load_ready_q <= 1'b0;
            load_done_q  <= 1'b1;
            err_q        <= (w_word_next != csum_q);
          end
        end
`endif

        LD_DONE: begin
          state_q <= LD_IDLE;
          stall_q <= 1'b0;
        end

        default: begin
          state_q      <= LD_IDLE;
          load_ready_q <= 1'b0;
          stall_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule : inst_mem_loader
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_inst_mem_loader                                         |
// | Description : Self-checking bench for inst_mem_loader. A driver issues   |
// |               loads and fetches and queues expected responses; a monitor |
// |               on the falling edge compares DUT outputs against them.     |
// |               Honors INST_LOAD_CHECKSUM_EN the same way as the design.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_inst_mem_loader;

  localparam int MEM_WORDS = 1024;
  localparam int ADDR_W    = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              ce;
  logic [31:0]       addr;
  logic [31:0]       inst;
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              load_valid;
  logic [7:0]        load_byte;
  logic              load_ready;
  logic              load_done;
  logic              load_err;
  logic              stall_req;

  inst_mem_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .addr       (addr),
    .inst       (inst),
    .load_start (load_start),
    .load_len   (load_len),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_err   (load_err),
    .stall_req  (stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   edge_no;
    logic err;
  } done_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          edge_n = 0;
  int          last_acc = 0;
  bit          chk_stall = 0;
  bit          fetch_on = 0;
  bit          after_done = 0;
  done_t       exp_done[$];
  logic [31:0] exp_inst[$];
  logic [7:0]  tx_q[$];
  logic [31:0] wr_words[$];
  logic [31:0] model_mem [MEM_WORDS];
  bit          model_known [MEM_WORDS];

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: everything sampled on the falling edge.
  always @(negedge clk) begin
    done_t e;
    if (after_done) begin
      check("stall_release", {31'd0, stall_req}, 32'd0);
      after_done = 0;
    end
    if (chk_stall) begin
      check("stall_busy", {31'd0, stall_req}, 32'd1);
      if (ce) check("inst_nop_during_load", inst, 32'd0);
    end
    if (load_done) begin
      if (exp_done.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_done.pop_front();
        check("done_edge", edge_n, e.edge_no);
        check("done_err", {31'd0, load_err}, {31'd0, e.err});
        after_done = 1;
      end
    end
    if (fetch_on) begin
      if (exp_inst.size() == 0) check("fetch_no_expect", 32'd1, 32'd0);
      else check("fetch_inst", inst, exp_inst.pop_front());
    end
  end

  // Drives tx_q out byte by byte; mode 0 continuous, 1 every other cycle,
  // 2 random. glitch_after >= 0 pulses load_start after that many bytes.
  task automatic push_bytes(input int mode, input int glitch_after);
    int k = 0;
    int nacc = 0;
    int guard = 0;
    int limit;
    bit gdone = 0;
    bit acc;
    limit = tx_q.size() * 20 + 100;
    while (tx_q.size() > 0) begin
      case (mode)
        0:       load_valid = 1'b1;
        1:       load_valid = (k % 2 == 0);
        default: load_valid = ($urandom_range(0, 1) == 1);
      endcase
      load_byte = tx_q[0];
      ce   = ($urandom_range(0, 1) == 1);
      addr = $urandom;
      if (glitch_after >= 0 && !gdone && nacc == glitch_after) begin
        load_start = 1'b1;
        load_len   = (ADDR_W+1)'(7);
        gdone      = 1;
      end
      @(negedge clk);
      acc = load_valid && load_ready;
      @(posedge clk); #1;
      load_start = 1'b0;
      if (acc) begin
        void'(tx_q.pop_front());
        nacc++;
        last_acc = edge_n;
      end
      k++;
      guard++;
      if (guard > limit) begin
        n_vec++;
        n_err++;
        $display("FAIL byte_handshake: %0d bytes pending after %0d cycles, expected 0", tx_q.size(), guard);
        tx_q.delete();
      end
    end
    load_valid = 1'b0;
    ce = 1'b0;
  endtask

  task automatic do_load(input int len_req, input int mode, input logic [31:0] csum_delta,
                         input int glitch_after);
    int          n;
    int          g;
    int          data_last;
    logic [31:0] csum;
    logic [31:0] w;
    done_t       e;
    csum = 32'd0;
    n = (len_req > MEM_WORDS) ? MEM_WORDS : len_req;
    while (wr_words.size() < n) wr_words.push_back($urandom);
    load_len   = (ADDR_W+1)'(len_req);
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    chk_stall  = 1;
    if (n == 0) begin
      e.edge_no = edge_n;
      e.err     = 1'b0;
      exp_done.push_back(e);
    end else begin
      for (int i = 0; i < n; i++) begin
        w = wr_words[i];
        csum ^= w;
        for (int b = 3; b >= 0; b--) tx_q.push_back(w[8*b +: 8]);
      end
      push_bytes(mode, glitch_after);
      data_last = last_acc;
`ifdef INST_LOAD_CHECKSUM_EN
      w = csum ^ csum_delta;
      for (int b = 3; b >= 0; b--) tx_q.push_back(w[8*b +: 8]);
      push_bytes(mode, -1);
      e.edge_no = last_acc;
      e.err     = (csum_delta != 32'd0);
`else
      e.edge_no = data_last + 1;
      e.err     = 1'b0;
`endif
      exp_done.push_back(e);
      for (int i = 0; i < n; i++) begin
        model_mem[i]   = wr_words[i];
        model_known[i] = 1;
      end
    end
    wr_words.delete();
    g = 0;
    while (exp_done.size() > 0) begin
      @(posedge clk); #1;
      g++;
      if (g > 64) begin
        n_vec++;
        n_err++;
        $display("FAIL done_timeout: load_done absent after %0d cycles, expected a pulse", g);
        exp_done.delete();
      end
    end
    chk_stall = 0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic ce_v);
    logic [ADDR_W-1:0] idx;
    idx = a[ADDR_W+1:2];
    if (ce_v && !model_known[idx]) return;
    ce   = ce_v;
    addr = a;
    exp_inst.push_back(ce_v ? model_mem[idx] : 32'd0);
    fetch_on = 1;
    @(posedge clk); #1;
    fetch_on = 0;
    ce = 1'b0;
  endtask

  initial begin
    logic [31:0] w0_new;
    logic [31:0] w1_new;
    rst = 1'b1; ce = 1'b0; addr = 32'd0; load_start = 1'b0; load_len = '0;
    load_valid = 1'b0; load_byte = 8'd0;
    for (int i = 0; i < MEM_WORDS; i++) model_known[i] = 0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    check("rst_ready", {31'd0, load_ready}, 32'd0);
    check("rst_done", {31'd0, load_done}, 32'd0);
    check("rst_err", {31'd0, load_err}, 32'd0);
    check("rst_inst_ce0", inst, 32'd0);
    @(posedge clk); #1;

    // Single-word load
    wr_words.push_back(32'h3401_1100);
    do_load(1, 0, 32'd0, -1);
    fetch(32'h0, 1'b1);
    fetch(32'h0, 1'b0);

    // Three words with throttled valid, then wrap and byte-offset fetches
    do_load(3, 1, 32'd0, -1);
    fetch(32'h0, 1'b1);
    fetch(32'h4, 1'b1);
    fetch(32'h8, 1'b1);
    fetch(32'h1000, 1'b1);
    fetch(32'h0000_100B, 1'b1);

    // Zero-length load: done next cycle, no write
    do_load(0, 0, 32'd0, -1);
    fetch(32'h0, 1'b1);

    // load_start during LOAD is ignored
    do_load(2, 0, 32'd0, 2);
    fetch(32'h0, 1'b1);
    fetch(32'h4, 1'b1);
    fetch(32'h8, 1'b1);

`ifdef INST_LOAD_CHECKSUM_EN
    wr_words.push_back(32'h1111_1111);
    wr_words.push_back(32'h2222_2222);
    do_load(2, 0, 32'd0, -1);
    wr_words.push_back(32'h1111_1111);
    wr_words.push_back(32'h2222_2222);
    do_load(2, 0, 32'h0000_0007, -1);
`endif

    // Randomized loads
    for (int t = 0; t < 6; t++) begin
      do_load($urandom_range(1, 6), $urandom_range(0, 2),
              ($urandom_range(0, 1) == 1) ? $urandom : 32'd0, -1);
      for (int a = 0; a < 8; a++) fetch(32'(a * 4), 1'b1);
    end

    // Reset mid-load: word 0 written, two bytes of word 1 then reset
    w0_new = $urandom;
    w1_new = $urandom;
    load_len = (ADDR_W+1)'(2);
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    chk_stall = 1;
    for (int b = 3; b >= 0; b--) tx_q.push_back(w0_new[8*b +: 8]);
    tx_q.push_back(w1_new[31:24]);
    tx_q.push_back(w1_new[23:16]);
    push_bytes(0, -1);
    rst = 1'b1;
    chk_stall = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_stall", {31'd0, stall_req}, 32'd0);
    check("midrst_ready", {31'd0, load_ready}, 32'd0);
    @(posedge clk); #1;
    model_mem[0] = w0_new;
    model_known[0] = 1;
    fetch(32'h0, 1'b1);
    fetch(32'h4, 1'b1);

    // Oversized length clamps to MEM_WORDS
    do_load(2000, 0, 32'd0, -1);
    fetch(32'h0, 1'b1);
    fetch(32'h0000_07FC, 1'b1);
    fetch(32'h0000_0FFC, 1'b1);
    fetch(32'h0000_1000, 1'b1);
    fetch(32'hFFFF_F7FE, 1'b1);
    for (int t = 0; t < 8; t++) fetch($urandom, 1'b1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_inst_mem_loader
`default_nettype wire
